// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int PC_W   = 5;
  localparam int WORD_W = 9;
  localparam int WD_W   = 4;

  // Watchdog: an instruction may spend at most WD_LIMIT cycles in EXEC
  // without Done before the unit gives up and halts with Error.
  localparam logic [WD_W-1:0] WD_LIMIT = 4'd15;
  localparam logic [WD_W-1:0] WD_LAST  = WD_LIMIT - 4'd1;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_IFETCH = 3'd3,
    S_ILOAD  = 3'd4,
    S_ISSUE  = 3'd5,
    S_EXEC   = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  // Instruction word layout is IIIXXXYYY; the opcode is the top three bits.
  function automatic logic [2:0] opcode_of(input logic [WORD_W-1:0] word);
    return word[WORD_W-1 -: 3];
  endfunction

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter: clearable, incrementable, wraps naturally at 2**PC_W.
module pc_counter
  import fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  // Clear has priority over increment; wrap from 31 to 0 is intentional.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: reads words from a synchronous ROM, holds the
// instruction and bus data words, and hands each instruction to the control
// unit with a one-cycle Run pulse. A watchdog halts the unit if the control
// unit never reports Done.
//
// Handshake: Run is a one-cycle request issued from ISSUE; the control unit
// answers with Done, which is only honoured while the unit waits in EXEC and
// is ignored in every other state.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  output logic [PC_W-1:0]   MemAddr,
  input  logic [WORD_W-1:0] MemData,
  output logic [WORD_W-1:0] Instrucao,
  output logic [WORD_W-1:0] DIN,
  output logic              Run,
  input  logic              Done,
  output logic              Busy,
  output logic              Halted,
  output logic              Error,
  output state_t            fsm_state
);

  state_t          state;
  state_t          next_state;
  logic [WD_W-1:0] wd;
  logic            pc_clear;
  logic            pc_inc;
  logic            load_ir;
  logic            load_imm;
  logic            wd_clear;
  logic            wd_inc;
  logic            err_set;
  logic            err_clr;

  pc_counter u_pc (
    .clk   (Clock),
    .rst   (Resetn),
    .clear (pc_clear),
    .inc   (pc_inc),
    .pc    (MemAddr)
  );

  // State register; Resetn is active-high despite its name.
  always_ff @(posedge Clock) begin
    if (Resetn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control decode. The ROM answers one cycle after the
  // address, so FETCH/IFETCH only present the address and LOAD/ILOAD capture.
  always_comb begin
    next_state = state;
    pc_clear   = 1'b0;
    pc_inc     = 1'b0;
    load_ir    = 1'b0;
    load_imm   = 1'b0;
    wd_clear   = 1'b0;
    wd_inc     = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    Run        = 1'b0;
    case (state)
      S_IDLE, S_HALT: begin
        if (Start) begin
          pc_clear   = 1'b1;
          err_clr    = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_FETCH: next_state = S_LOAD;
      S_LOAD: begin
        load_ir = 1'b1;
        pc_inc  = 1'b1;
        case (opcode_of(MemData))
          OP_HALT: next_state = S_HALT;
          OP_MVI:  next_state = S_IFETCH;
          default: next_state = S_ISSUE;
        endcase
      end
      S_IFETCH: next_state = S_ILOAD;
      S_ILOAD: begin
        load_imm   = 1'b1;
        pc_inc     = 1'b1;
        next_state = S_ISSUE;
      end
      S_ISSUE: begin
        Run        = 1'b1;
        wd_clear   = 1'b1;
        next_state = S_EXEC;
      end
      S_EXEC: begin
        if (Done) begin
          next_state = S_FETCH;
        end else if (wd == WD_LAST) begin
          // This Done-less cycle brings the watchdog to its limit.
          wd_inc     = 1'b1;
          err_set    = 1'b1;
          next_state = S_HALT;
        end else begin
          wd_inc = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Instruction and bus data registers; both hold until the next capture.
  always_ff @(posedge Clock) begin
    if (Resetn) begin
      Instrucao <= '0;
      DIN       <= '0;
    end else if (load_ir) begin
      Instrucao <= MemData;
      DIN       <= MemData;
    end else if (load_imm) begin
      DIN <= MemData;
    end
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge Clock) begin
    if (Resetn) begin
      wd    <= '0;
      Error <= 1'b0;
    end else begin
      if (wd_clear) begin
        wd <= '0;
      end else if (wd_inc) begin
        wd <= wd + 1'b1;
      end
      if (err_set) begin
        Error <= 1'b1;
      end else if (err_clr) begin
        Error <= 1'b0;
      end
    end
  end

  assign Busy      = (state != S_IDLE) && (state != S_HALT);
  assign Halted    = (state == S_HALT);
  assign fsm_state = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// programs checked against an instruction-level reference model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Start;
  logic       Done;
  logic [4:0] MemAddr;
  logic [8:0] MemData;
  logic [8:0] Instrucao;
  logic [8:0] DIN;
  logic       Run;
  logic       Busy;
  logic       Halted;
  logic       Error;
  state_t     fsm_state;

  logic [8:0]  rom [32];
  logic [17:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          run_count = 0;
  int          ref_pc = 0;
  logic [8:0]  ref_word = '0;
  bit          wrap_seen = 0;

  // ---------------- clock / memory / DUT ----------------
  always #5 Clock = ~Clock;

  always @(posedge Clock) MemData <= rom[MemAddr];

  fetch_unit dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Start     (Start),
    .MemAddr   (MemAddr),
    .MemData   (MemData),
    .Instrucao (Instrucao),
    .DIN       (DIN),
    .Run       (Run),
    .Done      (Done),
    .Busy      (Busy),
    .Halted    (Halted),
    .Error     (Error),
    .fsm_state (fsm_state)
  );

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete (n_cmp=%0d)", n_cmp);
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: each Run pulse must carry the next predicted {Instrucao, DIN}.
  always @(negedge Clock) begin : sb_mon
    logic [17:0] e;
    if (Run === 1'b1) begin
      run_count++;
      check_eq("sb_pending_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("sb_instr_din", {Instrucao, DIN}, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset(input bit noise);
    Resetn = 1'b1;
    Start  = noise;
    Done   = noise;
    step();
    Resetn = 1'b0;
    Start  = 1'b0;
    Done   = 1'b0;
    exp_q.delete();
    check_eq("rst_memaddr", MemAddr, 0);
    check_eq("rst_instrucao", Instrucao, 0);
    check_eq("rst_din", DIN, 0);
    check_eq("rst_run", Run, 0);
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_halted", Halted, 0);
    check_eq("rst_error", Error, 0);
  endtask

  task automatic do_start();
    Start = 1'b1;
    step();
    Start  = 1'b0;
    ref_pc = 0;
    check_eq("start_pc", MemAddr, 0);
    check_eq("start_error_clear", Error, 0);
    check_eq("start_busy", Busy, 1);
    check_eq("start_halted", Halted, 0);
  endtask

  // Called while the unit is in FETCH. The model walks the program one
  // instruction at a time: a halt consumes one word and issues nothing,
  // mvi consumes two words, everything else one; Run (or Halted) follows
  // two cycles after FETCH, or four for mvi.
  task automatic run_instr(input bit inject, output bit hlt);
    logic [8:0] word;
    logic [8:0] din;
    bit         mvi;
    int         lat;
    int         runs0;
    bit         got;
    word = rom[ref_pc];
    din  = word;
    hlt  = (word[8:6] == 3'b111);
    mvi  = (word[8:6] == 3'b001);
    if (mvi && ref_pc == 31) wrap_seen = 1;
    ref_pc = (ref_pc + 1) % 32;
    if (mvi) begin
      din    = rom[ref_pc];
      ref_pc = (ref_pc + 1) % 32;
    end
    ref_word = word;
    if (!hlt) exp_q.push_back({word, din});
    runs0 = run_count;
    lat   = 0;
    got   = 0;
    while (!got && lat < 8) begin
      if (inject) begin
        Start = ($urandom_range(0, 3) == 0);
        Done  = ($urandom_range(0, 3) == 0);
      end
      step();
      lat++;
      got = (Run === 1'b1) || (Halted === 1'b1);
    end
    Start = 1'b0;
    Done  = 1'b0;
    check_eq("pc_after_load", MemAddr, ref_pc);
    check_eq("instrucao", Instrucao, word);
    if (hlt) begin
      check_eq("halt_latency", lat, 2);
      check_eq("halted", Halted, 1);
      check_eq("busy_in_halt", Busy, 0);
      check_eq("run_in_halt", Run, 0);
      check_eq("no_run_on_halt", run_count, runs0);
    end else begin
      check_eq("run_latency", lat, mvi ? 4 : 2);
      check_eq("run", Run, 1);
      check_eq("din", DIN, din);
      check_eq("busy_in_issue", Busy, 1);
    end
  endtask

  // Called in ISSUE. Done rises after d Done-less EXEC cycles; with d >= 15
  // the watchdog expires after the 15th EXEC cycle and the unit halts.
  task automatic finish_exec(input int d, input bit inject, output bit timed_out);
    bit acc;
    acc  = 0;
    Done = 1'b0;
    step();
    check_eq("run_one_cycle", Run, 0);
    check_eq("busy_in_exec", Busy, 1);
    for (int k = 1; k <= 15 && !acc; k++) begin
      if (k == d + 1) begin
        Done = 1'b1;
        step();
        Done = 1'b0;
        acc  = 1;
      end else begin
        if (k == 15) check_eq("exec_before_timeout", Halted, 0);
        if (inject) Start = ($urandom_range(0, 3) == 0);
        step();
        Start = 1'b0;
      end
    end
    timed_out = !acc;
    check_eq("instr_held", Instrucao, ref_word);
    if (acc) begin
      check_eq("fetch_pc_after_done", MemAddr, ref_pc);
      check_eq("busy_after_done", Busy, 1);
      check_eq("no_error", Error, 0);
    end else begin
      check_eq("timeout_halted", Halted, 1);
      check_eq("timeout_error", Error, 1);
      check_eq("timeout_busy", Busy, 0);
      check_eq("timeout_pc_held", MemAddr, ref_pc);
    end
  endtask

  task automatic run_program(input int max_n, input int dmax, input bit inject);
    bit h;
    bit to;
    int n;
    h  = 0;
    to = 0;
    n  = 0;
    while (n < max_n && !h && !to) begin
      run_instr(inject, h);
      if (!h) finish_exec($urandom_range(0, dmax), inject, to);
      n++;
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    bit         h;
    bit         to;
    int         runs0;
    int         n;
    logic [2:0] ops [6];
    logic [2:0] op;
    ops = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    Resetn = 1'b1;
    Start  = 1'b0;
    Done   = 1'b0;
    foreach (rom[i]) rom[i] = '0;
    step();
    do_reset(1);

    // mv: Run in cycle 3, Done two cycles later, then FETCH at PC=1.
    rom[0] = 9'h00A;
    rom[1] = 9'h1C0;
    do_start();
    run_instr(0, h);
    check_eq("mv_instrucao", Instrucao, 9'h00A);
    finish_exec(1, 0, to);
    check_eq("mv_fetch_pc", MemAddr, 1);
    run_instr(0, h);
    Done = 1'b1;
    step();
    Done = 1'b0;
    check_eq("done_in_halt_ignored", Halted, 1);
    check_eq("done_in_halt_pc", MemAddr, 2);

    // mvi then halt; a later Start restarts from address 0.
    rom[0] = 9'h058;
    rom[1] = 9'h1FF;
    rom[2] = 9'h1C0;
    do_start();
    run_instr(0, h);
    check_eq("mvi_instrucao", Instrucao, 9'h058);
    check_eq("mvi_din", DIN, 9'h1FF);
    check_eq("mvi_pc", MemAddr, 2);
    finish_exec(0, 0, to);
    run_instr(0, h);
    check_eq("halt_pc", MemAddr, 3);
    check_eq("halt_busy", Busy, 0);
    do_start();
    run_instr(0, h);
    finish_exec(2, 0, to);
    run_instr(0, h);

    // Watchdog timeout, then Start clears Error.
    rom[0] = 9'h08B;
    rom[1] = 9'h1C0;
    do_start();
    run_instr(0, h);
    finish_exec(20, 0, to);
    do_start();
    run_instr(0, h);
    finish_exec(0, 0, to);
    run_instr(0, h);

    // PC wrap: mvi at address 31 takes its immediate from address 0.
    for (int i = 0; i < 31; i++) begin
      op = ops[$urandom_range(0, 5)];
      if (i >= 1 && i <= 29 && $urandom_range(0, 5) == 0) op = 3'b001;
      rom[i] = {op, 6'($urandom_range(0, 63))};
    end
    rom[31]   = 9'h048;
    wrap_seen = 0;
    do_start();
    n = 0;
    while (!wrap_seen && n < 40) begin
      run_instr(1, h);
      finish_exec($urandom_range(0, 5), 1, to);
      n++;
    end
    check_eq("wrap_pc", MemAddr, 1);
    check_eq("wrap_imm", DIN, rom[0]);
    run_instr(1, h);
    finish_exec($urandom_range(0, 5), 1, to);
    do_reset(0);

    // Fully random programs, including halts and watchdog timeouts.
    for (int p = 0; p < 4; p++) begin
      foreach (rom[i]) rom[i] = 9'($urandom_range(0, 511));
      do_start();
      run_program(20, 17, 1);
      do_reset(0);
    end

    // Reset while in ILOAD aborts without a Run pulse.
    rom[0] = 9'h050;
    rom[1] = 9'h0AA;
    do_start();
    step();
    step();
    step();
    check_eq("iload_busy", Busy, 1);
    runs0 = run_count;
    do_reset(1);
    step();
    step();
    check_eq("abort_no_run", run_count, runs0);
    check_eq("abort_idle_busy", Busy, 0);
    check_eq("abort_idle_pc", MemAddr, 0);

    check_eq("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port Resetn, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port Start, input, 1 bit: begins program execution from address 0.
REQ-004 The block SHALL have port MemAddr, output, 5 bits: instruction memory address.
REQ-005 The block SHALL have port MemData, input, 9 bits: synchronous ROM read data, valid one cycle after MemAddr.
REQ-006 The block SHALL have port Instrucao, output, 9 bits: held instruction word IIIXXXYYY (opcode [8:6], Rx [5:3], Ry [2:0]), registered.
REQ-007 The block SHALL have port DIN, output, 9 bits: registered data word for the processor bus (mvi immediate, else copy of Instrucao).
REQ-008 The block SHALL have port Run, output, 1 bit: one-cycle pulse to the control unit starting an instruction.
REQ-009 The block SHALL have port Done, input, 1 bit: control unit instruction-complete flag.
REQ-010 The block SHALL have port Busy, output, 1 bit: high in every state except IDLE and HALT.
REQ-011 The block SHALL have port Halted, output, 1 bit: high in HALT.
REQ-012 The block SHALL have port Error, output, 1 bit: sticky watchdog-timeout flag.

Function
REQ-013 The block SHALL implement FSM states IDLE, FETCH, LOAD, IFETCH, ILOAD, ISSUE, EXEC, HALT.
REQ-014 The block SHALL drive MemAddr from the 5-bit PC register in every state.
REQ-015 In IDLE or HALT, Start=1 SHALL clear PC and Error and go to FETCH; Start in any other state SHALL be ignored.
REQ-016 FETCH SHALL last one cycle and go to LOAD.
REQ-017 In LOAD the block SHALL capture MemData into Instrucao and DIN and increment PC.
REQ-018 From LOAD: opcode 111 -> HALT (no Run); opcode 001 -> IFETCH; other opcodes -> ISSUE.
REQ-019 IFETCH SHALL last one cycle and go to ILOAD.
REQ-020 In ILOAD the block SHALL capture MemData into DIN only, increment PC, and go to ISSUE.
REQ-021 In ISSUE, Run SHALL be 1 for exactly one cycle, then the FSM SHALL go to EXEC; Run SHALL be 0 in all other states.
REQ-022 Latency SHALL be: Start sampled at edge 0 -> Run high in cycle 3 (non-mvi) or cycle 5 (mvi).
REQ-023 In EXEC, Done=1 SHALL go to FETCH on the next edge; Done in any other state SHALL be ignored.
REQ-024 A 4-bit watchdog SHALL clear on entry to EXEC and increment each EXEC cycle without Done.
REQ-025 When the watchdog reaches 15 with Done=0, the FSM SHALL go to HALT and set Error.
REQ-026 PC SHALL wrap from 31 to 0 without error, including an mvi immediate fetched at wrap.
REQ-027 Instrucao and DIN SHALL hold their values until the next LOAD or ILOAD.

Reset
REQ-028 Resetn=1 at a rising edge SHALL force IDLE and PC=0, Instrucao=0, DIN=0, watchdog=0, Run=0, Busy=0, Halted=0, Error=0, MemAddr=0.
REQ-029 Reset SHALL take priority over Start and Done in the same cycle and SHALL abort any state mid-operation with no Run pulse.

Structure
REQ-030 Opcode constants (OP_MV=000, OP_MVI=001, OP_ADD=010, OP_SUB=011, OP_HALT=111), state encoding, PC width 5, word width 9 and watchdog limit 15 SHALL live in a shared package.
REQ-031 The PC SHALL be a sub-module pc_counter, with clear, increment and a 5-bit output.
REQ-032 The FSM, instruction and data registers and watchdog SHALL stay in fetch_unit.

Verification
REQ-033 The bench SHALL cover: ROM[0]=000_001_010 (mv), Start pulse -> Instrucao=0x00A, Run in cycle 3; Done 2 cycles later -> FETCH at PC=1.
REQ-034 The bench SHALL cover: ROM[0]=001_011_000, ROM[1]=0x1FF -> Instrucao=0x058, DIN=0x1FF, Run in cycle 5, PC=2 afterwards.
REQ-035 The bench SHALL cover: ROM[2]=111_000_000 -> Halted=1, Busy=0, no Run, PC=3; a following Start restarts at PC=0.
REQ-036 The bench SHALL cover: Done held 0 in EXEC -> HALT with Error=1 after 15 cycles; Start clears Error.
REQ-037 The bench SHALL cover: mvi at address 31 -> immediate read from address 0, PC=1 afterwards; Start and Done pulses outside their accepting states cause no change.
REQ-038 The bench SHALL cover: Resetn asserted in ILOAD -> next cycle IDLE with all outputs 0 and no Run pulse.
